// File: rtl/req_ack_responder.sv
// Request/acknowledge responder: answers each accepted req with a one-cycle ack
// after DELAY cycles (plus stalled cycles), flags dropped requests, counts acks.
module req_ack_responder #(
   parameter int unsigned DELAY = 1,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req,
   input  logic             stall,
   output logic             ack,
   output logic             busy,
   output logic             overrun,
   output logic [CNT_W-1:0] done_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      ACK   = 2'd2
   } state_t;

   localparam int          LOAD_I = (DELAY >= 2) ? int'(DELAY) - 1 : 0;
   localparam logic [3:0]  LOAD   = 4'(LOAD_I);

   state_t           r_state;
   logic [3:0]       r_cnt;
   logic             r_overrun;
   logic [CNT_W-1:0] r_done_cnt;
   logic             w_ack;

   // DELAY=0 answers in the same cycle, so ack must be gated by rst_n directly.
   assign w_ack = (DELAY == 0) ? (rst_n & req & (r_state == IDLE))
                               : (r_state == ACK);

   // NOTE: every state register sits on the async reset and uses <= so all
   // updates see the pre-edge values of r_state/r_cnt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= 4'd0;
         r_overrun  <= 1'b0;
         r_done_cnt <= '0;
      end else begin
         r_overrun <= 1'b0;
         if (w_ack) begin
            r_done_cnt <= r_done_cnt + CNT_W'(1);
         end
         case (r_state)
            IDLE, ACK: begin
               if (req && (DELAY == 1)) begin
                  r_state <= ACK;
               end else if (req && (DELAY >= 2)) begin
                  r_state <= COUNT;
                  r_cnt   <= LOAD;
               end else begin
                  r_state <= IDLE;
               end
            end
            COUNT: begin
               // A req arriving mid-countdown is dropped and reported next cycle.
               if (req) begin
                  r_overrun <= 1'b1;
               end
               if (!stall) begin
                  if (r_cnt == 4'd1) begin
                     r_state <= ACK;
                     r_cnt   <= 4'd0;
                  end else begin
                     r_cnt <= r_cnt - 4'd1;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign ack      = w_ack;
   assign busy     = (r_state == COUNT) || (r_state == ACK);
   assign overrun  = r_overrun;
   assign done_cnt = r_done_cnt;

endmodule

// File: tb/tb_req_ack_responder.sv
// Directed bench for req_ack_responder: five instances with different DELAY/CNT_W
// driven by hand-built per-cycle vectors with hand-computed expected outputs.
module tb_req_ack_responder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // index: 0=DELAY0, 1=DELAY1, 2=DELAY4, 3=DELAY3, 4=DELAY1/CNT_W2
   logic req_a   [5];
   logic stall_a [5];
   logic ack_a   [5];
   logic busy_a  [5];
   logic ovr_a   [5];
   logic [7:0] done_0, done_1, done_2, done_3;
   logic [1:0] done_4;

   int n_checks = 0;
   int n_bad    = 0;

   req_ack_responder #(.DELAY(0), .CNT_W(8)) u_d0 (
      .clk(clk), .rst_n(rst_n), .req(req_a[0]), .stall(stall_a[0]),
      .ack(ack_a[0]), .busy(busy_a[0]), .overrun(ovr_a[0]), .done_cnt(done_0));
   req_ack_responder #(.DELAY(1), .CNT_W(8)) u_d1 (
      .clk(clk), .rst_n(rst_n), .req(req_a[1]), .stall(stall_a[1]),
      .ack(ack_a[1]), .busy(busy_a[1]), .overrun(ovr_a[1]), .done_cnt(done_1));
   req_ack_responder #(.DELAY(4), .CNT_W(8)) u_d4 (
      .clk(clk), .rst_n(rst_n), .req(req_a[2]), .stall(stall_a[2]),
      .ack(ack_a[2]), .busy(busy_a[2]), .overrun(ovr_a[2]), .done_cnt(done_2));
   req_ack_responder #(.DELAY(3), .CNT_W(8)) u_d3 (
      .clk(clk), .rst_n(rst_n), .req(req_a[3]), .stall(stall_a[3]),
      .ack(ack_a[3]), .busy(busy_a[3]), .overrun(ovr_a[3]), .done_cnt(done_3));
   req_ack_responder #(.DELAY(1), .CNT_W(2)) u_w2 (
      .clk(clk), .rst_n(rst_n), .req(req_a[4]), .stall(stall_a[4]),
      .ack(ack_a[4]), .busy(busy_a[4]), .overrun(ovr_a[4]), .done_cnt(done_4));

   function automatic logic [31:0] done_of(input int sel);
      case (sel)
         0:       return 32'(done_0);
         1:       return 32'(done_1);
         2:       return 32'(done_2);
         3:       return 32'(done_3);
         default: return 32'(done_4);
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic apply_reset();
      for (int i = 0; i < 5; i++) begin
         req_a[i]   = 1'b0;
         stall_a[i] = 1'b0;
      end
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Bit c of each vector is cycle c; cycle 0 starts at reset release.
   // Expected done_cnt steps after every cycle the hand-made ack table says is high.
   task automatic run_seq(input int sel, input int n,
                          input logic [15:0] req_v, input logic [15:0] stall_v,
                          input logic [15:0] ack_v, input logic [15:0] busy_v,
                          input logic [15:0] ovr_v, input logic [31:0] mask);
      logic [31:0] exp_done;
      exp_done = 32'd0;
      for (int c = 0; c < n; c++) begin
         req_a[sel]   = req_v[c];
         stall_a[sel] = stall_v[c];
         @(negedge clk);
         check($sformatf("s%0d c%0d ack", sel, c), 32'(ack_a[sel]), 32'(ack_v[c]));
         check($sformatf("s%0d c%0d busy", sel, c), 32'(busy_a[sel]), 32'(busy_v[c]));
         check($sformatf("s%0d c%0d ovr", sel, c), 32'(ovr_a[sel]), 32'(ovr_v[c]));
         check($sformatf("s%0d c%0d done", sel, c), done_of(sel), exp_done & mask);
         if (ack_v[c]) exp_done = exp_done + 32'd1;
         @(posedge clk);
         #1;
      end
      req_a[sel]   = 1'b0;
      stall_a[sel] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      for (int i = 0; i < 5; i++) begin
         req_a[i]   = 1'b0;
         stall_a[i] = 1'b0;
      end
      rst_n = 1'b0;
      #1 req_a[0] = 1'b1;
      #1;
      check("d0 ack in reset", 32'(ack_a[0]), 32'd0);
      check("d0 busy in reset", 32'(busy_a[0]), 32'd0);
      check("d4 done in reset", done_of(2), 32'd0);

      // DELAY=0: req at cycle 5 -> ack in cycle 5, busy never high
      apply_reset();
      run_seq(0, 8, 16'h0020, 16'h0000, 16'h0020, 16'h0000, 16'h0000, 32'hFF);

      // DELAY=1: back-to-back req at 3,4 -> ack at 4,5, no overrun
      apply_reset();
      run_seq(1, 8, 16'h0018, 16'h0000, 16'h0030, 16'h0030, 16'h0000, 32'hFF);

      // DELAY=4: req at 2, stall 4-5 (and stray stall in ACK cycle 8) -> ack at 8
      apply_reset();
      run_seq(2, 11, 16'h0004, 16'h0130, 16'h0100, 16'h01F8, 16'h0000, 32'hFF);

      // DELAY=4: req at 2 and 3 -> overrun at 4, single ack at 6
      apply_reset();
      run_seq(2, 9, 16'h000C, 16'h0000, 16'h0040, 16'h0078, 16'h0010, 32'hFF);

      // DELAY=1, CNT_W=2: requests at 0,3,6,9,12 -> done 1,2,3,0,1
      apply_reset();
      run_seq(4, 15, 16'h1249, 16'h0000, 16'h2492, 16'h2492, 16'h0000, 32'h3);
      check("w2 done before clr", done_of(4), 32'd1);
      rst_n = 1'b0;
      #1;
      check("w2 done async clr", done_of(4), 32'd0);

      // DELAY=3: req at 2, reset asserted in cycle 4 abandons the request
      apply_reset();
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      req_a[3] = 1'b1;
      @(posedge clk);
      #1 req_a[3] = 1'b0;
      @(negedge clk);
      check("d3 busy c3", 32'(busy_a[3]), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("d3 busy async", 32'(busy_a[3]), 32'd0);
      check("d3 ack in reset", 32'(ack_a[3]), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check($sformatf("d3 post c%0d ack", c), 32'(ack_a[3]), 32'd0);
         check($sformatf("d3 post c%0d ovr", c), 32'(ovr_a[3]), 32'd0);
         check($sformatf("d3 post c%0d busy", c), 32'(busy_a[3]), 32'd0);
         check($sformatf("d3 post c%0d done", c), done_of(3), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule

// File: doc/req_ack_responder.md
REQ_ACK_RESPONDER -- requirements
Module: req_ack_responder

Interface
REQ-001 Parameter DELAY, default 1, SHALL set the cycles from a sampled req to its ack; legal range 0..15.
REQ-002 Parameter CNT_W, default 8, SHALL set the done_cnt width; legal range 1..32.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the asynchronous, active-low reset.
REQ-005 Port req, input, 1, SHALL be the request strobe, sampled each rising edge of clk.
REQ-006 Port stall, input, 1, SHALL freeze the delay countdown while high.
REQ-007 Port ack, output, 1, SHALL be the one-cycle acknowledge for an accepted request.
REQ-008 Port busy, output, 1, SHALL be high while a request is in flight (state COUNT or ACK).
REQ-009 Port overrun, output, 1, SHALL be a one-cycle pulse flagging a dropped request.
REQ-010 Port done_cnt, output, CNT_W, SHALL count completed acks.

Function
REQ-011 FSM states SHALL be exactly IDLE, COUNT and ACK, held in a registered state variable.
REQ-012 Accept: req high in IDLE or ACK SHALL be accepted.
REQ-013 Accept, DELAY=0: ack = req while the state is IDLE; the state SHALL stay IDLE; ack is combinational from req.
REQ-014 Accept, DELAY=1: next state SHALL be ACK, so ack is high exactly 1 cycle after req.
REQ-015 Accept, DELAY>=2: next state SHALL be COUNT with the counter loaded to DELAY-1.
REQ-016 COUNT: each cycle with stall low SHALL decrement the counter.
REQ-017 COUNT exit: counter==1 with stall low SHALL move the state to ACK.
REQ-018 COUNT stall: each cycle with stall high SHALL hold both the counter and the state; ack is then exactly DELAY cycles after req plus the number of stalled COUNT cycles.
REQ-019 ACK state: ack SHALL be high for exactly that one cycle.
REQ-020 ACK exit: the next state SHALL be IDLE, unless req is high in that cycle, in which case it is accepted per REQ-014/REQ-015 (back-to-back).
REQ-021 Overrun: req high while in COUNT SHALL be dropped, with no state change, and overrun SHALL pulse high on the following cycle.
REQ-022 Stall outside COUNT SHALL have no effect.
REQ-023 done_cnt SHALL increment by 1 on the clock edge ending every cycle in which ack is high.
REQ-024 done_cnt SHALL wrap from 2^CNT_W-1 to 0, with no saturation.
REQ-025 busy SHALL be decoded from the registered state only; with DELAY=0, busy SHALL be constantly 0.
REQ-026 ack is never high for two consecutive cycles, except under back-to-back accepts with DELAY<=1.
REQ-027 In any one cycle, ack SHALL follow from exactly one accepted req.

Reset
REQ-028 rst_n low SHALL immediately, without waiting for clk: set the state to IDLE, clear the counter, and drive busy=0, overrun=0, done_cnt=0.
REQ-029 ack SHALL be 0 during reset, including when DELAY=0.
REQ-030 Reset asserted mid-COUNT or in ACK SHALL abandon the in-flight request with no ack and no overrun afterwards.
REQ-031 Release: the first rising clk edge with rst_n high SHALL be treated as IDLE and may accept a req.

Verification
REQ-032 DELAY=0: req high at cycle 5 -> ack high in cycle 5, busy stays 0, done_cnt=1 after cycle 5.
REQ-033 DELAY=1: req at cycles 3 and 4 (back-to-back) -> ack in cycles 4 and 5, done_cnt=2, no overrun.
REQ-034 DELAY=4: req at cycle 2, stall high in cycles 4-5 -> ack in cycle 8, busy high in cycles 3-8.
REQ-035 DELAY=4: req at cycle 2 and again at cycle 3 -> overrun high in cycle 4, a single ack in cycle 6, done_cnt=1.
REQ-036 DELAY=3: req at cycle 2, rst_n low in cycle 4 -> busy=0 immediately, no ack ever, done_cnt=0.
REQ-037 CNT_W=2, DELAY=1: 5 spaced requests -> done_cnt steps 1, 2, 3, 0, 1.
